// File: rtl/pc_update_unit.sv
// rtl/pc_update_unit.sv - program counter register with branch decode, stall buffering and alignment
// Optional statistics counters enabled by defining PC_UPDATE_STATS_EN.
module pc_update_unit #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int ALIGN_BITS = 2
`ifdef PC_UPDATE_STATS_EN
  ,
  parameter int STAT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_write,
  input  logic             branch,
  input  logic [1:0]       br_mode,
  input  logic             zero,
  input  logic             neg,
  input  logic             stall,
  input  logic [WIDTH-1:0] pc_next,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_prev,
  output logic             pc_en,
  output logic             pend_valid,
  output logic             misalign
`ifdef PC_UPDATE_STATS_EN
  ,
  output logic [STAT_W-1:0] write_cnt,
  output logic [STAT_W-1:0] taken_cnt
`endif
);

  localparam logic [WIDTH-1:0] KEEP_MASK = {WIDTH{1'b1}} << ALIGN_BITS;

  logic             cond;
  logic             req;
  logic [WIDTH-1:0] tgt;
  logic             raw_mis;
  logic [WIDTH-1:0] pend_target;
  logic             pend_mis;
  logic [WIDTH-1:0] commit_tgt;
  logic             commit_mis;

  always_comb begin
    cond = 1'b0;
    case (br_mode)
      2'd0: cond = zero;
      2'd1: cond = ~zero;
      2'd2: cond = zero | neg;
      2'd3: cond = ~zero & ~neg;
      default: cond = 1'b0;
    endcase
  end

  assign req     = pc_write | (branch & cond);
  assign tgt     = pc_next & KEEP_MASK;
  assign raw_mis = |(pc_next & ~KEEP_MASK);

  // A fresh request always wins over a buffered one.
  assign pc_en      = ~reset & ~stall & (req | pend_valid);
  assign commit_tgt = req ? tgt : pend_target;
  assign commit_mis = req ? raw_mis : pend_mis;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      pc_prev     <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      pend_mis    <= 1'b0;
      misalign    <= 1'b0;
    end else begin
      misalign <= pc_en & commit_mis;
      if (pc_en) begin
        pc         <= commit_tgt;
        pc_prev    <= pc;
        pend_valid <= 1'b0;
      end else if (stall & req) begin
        pend_valid  <= 1'b1;
        pend_target <= tgt;
        pend_mis    <= raw_mis;
      end
    end
  end

`ifdef PC_UPDATE_STATS_EN
  logic taken;
  assign taken = branch & cond & ~pc_write;

  always_ff @(posedge clk) begin
    if (reset) begin
      write_cnt <= '0;
      taken_cnt <= '0;
    end else begin
      if (pc_en && write_cnt != '1) write_cnt <= write_cnt + STAT_W'(1);
      if (taken && taken_cnt != '1) taken_cnt <= taken_cnt + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pc_update_unit.sv
// tb/tb_pc_update_unit.sv - directed and randomized checks of pc_update_unit against a behavioural model
module tb_pc_update_unit;

  logic        clk = 1'b0;
  logic        reset, pc_write, branch, zero, neg, stall;
  logic [1:0]  br_mode;
  logic [31:0] pc_next;
  logic [31:0] pc, pc_prev;
  logic        pc_en, pend_valid, misalign;
`ifdef PC_UPDATE_STATS_EN
  logic [15:0] write_cnt, taken_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pc_update_unit dut (
    .clk(clk), .reset(reset), .pc_write(pc_write), .branch(branch),
    .br_mode(br_mode), .zero(zero), .neg(neg), .stall(stall),
    .pc_next(pc_next), .pc(pc), .pc_prev(pc_prev), .pc_en(pc_en),
    .pend_valid(pend_valid), .misalign(misalign)
`ifdef PC_UPDATE_STATS_EN
    , .write_cnt(write_cnt), .taken_cnt(taken_cnt)
`endif
  );

  typedef struct {
    logic [31:0] target;
    bit          mis;
  } pend_t;

  logic [31:0] m_pc, m_prev;
  bit          m_mis;
  pend_t       m_pend[$];
  bit          m_en;
  int unsigned m_wcnt, m_tcnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit branch_taken(input logic [1:0] mode, input bit z, input bit n);
    case (mode)
      2'd0: return z;
      2'd1: return !z;
      2'd2: return z || n;
      default: return !z && !n;
    endcase
  endfunction

  // One clock: drive inputs, check pc_en before the edge, advance the model, check registers after.
  task automatic cyc(input bit r, input bit pw, input bit br, input logic [1:0] mode,
                     input bit z, input bit n, input bit st, input logic [31:0] nx);
    bit req, raw_mis;
    logic [31:0] tgt;
    reset = r; pc_write = pw; branch = br; br_mode = mode;
    zero = z; neg = n; stall = st; pc_next = nx;
    req     = pw || (br && branch_taken(mode, z, n));
    tgt     = (nx / 4) * 4;
    raw_mis = (nx % 4) != 0;
    m_en    = !r && !st && (req || m_pend.size() > 0);
    #3;
    chk("pc_en", {31'd0, pc_en}, {31'd0, m_en});
    @(posedge clk);
    if (r) begin
      m_pc = 0; m_prev = 0; m_mis = 0; m_pend.delete();
      m_wcnt = 0; m_tcnt = 0;
    end else begin
      if (br && branch_taken(mode, z, n) && !pw && m_tcnt < 32'hFFFF) m_tcnt++;
      if (m_en) begin
        if (m_wcnt < 32'hFFFF) m_wcnt++;
        m_prev = m_pc;
        if (req) begin
          m_pc = tgt; m_mis = raw_mis;
        end else begin
          m_pc = m_pend[0].target; m_mis = m_pend[0].mis;
        end
        m_pend.delete();
      end else begin
        m_mis = 0;
        if (st && req) begin
          m_pend.delete();
          m_pend.push_back('{target: tgt, mis: raw_mis});
        end
      end
    end
    #1;
    chk("pc", pc, m_pc);
    chk("pc_prev", pc_prev, m_prev);
    chk("pend_valid", {31'd0, pend_valid}, {31'd0, m_pend.size() > 0});
    chk("misalign", {31'd0, misalign}, {31'd0, m_mis});
`ifdef PC_UPDATE_STATS_EN
    chk("write_cnt", {16'd0, write_cnt}, m_wcnt);
    chk("taken_cnt", {16'd0, taken_cnt}, m_tcnt);
`endif
  endtask

  initial begin
    m_pc = 0; m_prev = 0; m_mis = 0; m_wcnt = 0; m_tcnt = 0;
    reset = 1; pc_write = 0; branch = 0; br_mode = 0; zero = 0; neg = 0; stall = 0; pc_next = 0;
    @(posedge clk); #1;

    cyc(1, 0, 0, 0, 0, 0, 0, 32'h0);
    cyc(1, 0, 0, 0, 0, 0, 0, 32'h0);
    chk("reset_pc", pc, 32'h0);
    chk("reset_pend", {31'd0, pend_valid}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 1, 0, 0, 32'h44);
      chk("idle_en", {31'd0, pc_en}, 32'h0);
    end
    chk("idle_pc", pc, 32'h0);

    cyc(0, 0, 1, 2'd0, 1, 0, 0, 32'h40);
    chk("beq_pc", pc, 32'h40);
    cyc(0, 0, 1, 2'd1, 1, 0, 0, 32'h80);
    chk("bne_pc", pc, 32'h40);
    cyc(0, 0, 1, 2'd2, 0, 1, 0, 32'h80);
    chk("blez_pc", pc, 32'h80);
    cyc(0, 0, 1, 2'd3, 0, 0, 0, 32'hC0);
    chk("bgtz_pc", pc, 32'hC0);

    cyc(0, 1, 0, 0, 0, 0, 1, 32'h100);
    chk("stall_pend", {31'd0, pend_valid}, 32'h1);
    chk("stall_pc", pc, 32'hC0);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 1, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 0, 32'h0);
    chk("release_en", {31'd0, m_en}, 32'h1);
    chk("release_pc", pc, 32'h100);
    chk("release_prev", pc_prev, 32'hC0);

    cyc(0, 1, 0, 0, 0, 0, 1, 32'h100);
    cyc(0, 1, 0, 0, 0, 0, 0, 32'h200);
    chk("override_pc", pc, 32'h200);
    cyc(0, 0, 0, 0, 0, 0, 0, 32'h0);
    chk("override_hold", pc, 32'h200);

    cyc(0, 1, 0, 0, 0, 0, 0, 32'h103);
    chk("align_pc", pc, 32'h100);
    chk("align_mis", {31'd0, misalign}, 32'h1);
    cyc(0, 0, 0, 0, 0, 0, 0, 32'h0);
    chk("align_mis_clr", {31'd0, misalign}, 32'h0);

    cyc(0, 1, 0, 0, 0, 0, 1, 32'h80);
    cyc(1, 0, 0, 0, 0, 0, 1, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 0, 32'h0);
    chk("rst_stall_pc", pc, 32'h0);
    chk("rst_stall_pend", {31'd0, pend_valid}, 32'h0);

    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
          2'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 1),
          ($urandom_range(0, 2) == 0), $urandom);
    end

`ifdef PC_UPDATE_STATS_EN
    for (int i = 0; i < 70000; i++) cyc(0, 1, 0, 0, 0, 0, 0, 32'(i * 4));
    chk("write_cnt_sat", {16'd0, write_cnt}, 32'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
